// File: rtl/i2s_sample_packer.sv
// Packs one signed PCM sample per strobe into KEEP_BYTES MSB-first FIFO bytes,
// with optional round-half-up/saturate, backpressure handling and drop statistics.
module i2s_sample_packer #(
  parameter int DATA_SIZE  = 24,
  parameter int KEEP_BYTES = 2,
  parameter int ROUND      = 1,
  parameter int DROP_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 sample_valid,
  input  logic [DATA_SIZE-1:0] sample_data,
  input  logic                 fifo_full,
  output logic                 fifo_wr_en,
  output logic [7:0]           fifo_wr_data,
  output logic                 busy,
  output logic                 overflow,
  output logic [DROP_W-1:0]    drop_count,
  input  logic                 clear_stats
);

  localparam int KW = 8 * KEEP_BYTES;
  localparam int L  = DATA_SIZE - KW;
  localparam int IW = (KEEP_BYTES > 1) ? $clog2(KEEP_BYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(KEEP_BYTES - 1);

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [KW-1:0]   r_shift;
  logic [IW-1:0]   r_byte_idx;
  logic [KW-1:0]   w_reduced;
  logic            w_wr;
  logic            w_last;
  logic            w_take;
  logic            w_accept;
  logic            w_drop;

  generate
    if (ROUND != 0 && L > 0) begin : g_round
      localparam logic [DATA_SIZE:0] HALF = {{DATA_SIZE{1'b0}}, 1'b1} << (L - 1);
      logic [DATA_SIZE:0] w_t;
      logic               w_sat;
      logic               w_unused;
      assign w_t      = {sample_data[DATA_SIZE-1], sample_data} + HALF;
      // Only non-negative inputs can cross the positive limit; the carry shows up in bit DATA_SIZE-1.
      assign w_sat    = !sample_data[DATA_SIZE-1] && w_t[DATA_SIZE-1];
      assign w_reduced = w_sat ? {1'b0, {(KW-1){1'b1}}} : w_t[DATA_SIZE-1:L];
      assign w_unused = ^{w_t[DATA_SIZE], w_t[L-1:0]};
    end else begin : g_trunc
      assign w_reduced = sample_data[DATA_SIZE-1:L];
      if (L > 0) begin : g_lsb
        logic w_unused;
        assign w_unused = ^sample_data[L-1:0];
      end
    end
  endgenerate

  assign w_wr     = (r_state == S_EMIT) && !fifo_full;
  assign w_last   = w_wr && (r_byte_idx == LAST_IDX);
  assign w_take   = sample_valid && enable;
  assign w_accept = w_take && ((r_state == S_IDLE) || w_last);
  assign w_drop   = w_take && (r_state == S_EMIT) && !w_last;

  assign fifo_wr_en   = w_wr;
  assign fifo_wr_data = r_shift[KW-1 -: 8];
  assign busy         = (r_state == S_EMIT);

  always_comb begin
    w_next = r_state;
    if (w_accept)    w_next = S_EMIT;
    else if (w_last) w_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_byte_idx <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_shift    <= w_reduced;
        r_byte_idx <= '0;
      end else if (w_wr) begin
        r_shift    <= r_shift << 8;
        r_byte_idx <= r_byte_idx + IW'(1);
      end
    end
  end

  // A drop coinciding with clear is still recorded on top of the cleared state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (clear_stats) begin
      overflow   <= w_drop;
      drop_count <= w_drop ? DROP_W'(1) : '0;
    end else if (w_drop) begin
      overflow <= 1'b1;
      if (drop_count != '1) drop_count <= drop_count + DROP_W'(1);
    end
  end

endmodule
